button_conditioner: RTL

BUTTON_CONDITIONER -- requirements
Module: button_conditioner

---
 rtl/btn_pkg.sv | 17 +
 rtl/btn_debounce_ch.sv | 122 ++++++++++++
 rtl/button_conditioner.sv | 48 ++++
 3 files changed

// File: rtl/btn_pkg.sv
// Shared constants and per-channel state type for the button conditioner.
package btn_pkg;
   localparam int NUM_BTN     = 6;
   localparam int NUM_DIR_BTN = 4;
   localparam int BTN_L       = 0;
   localparam int BTN_R       = 1;
   localparam int BTN_U       = 2;
   localparam int BTN_D       = 3;
   localparam int BTN_PLACE   = 4;
   localparam int BTN_RESET   = 5;

   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_PRESSED   = 2'd1,
      ST_REPEATING = 2'd2
   } btn_state_e;
endpackage

// File: rtl/btn_debounce_ch.sv
// One button channel: 2-flop sync, saturating debounce counter, press FSM, registered press pulse.
// Optional auto-repeat counter is built only when BTN_AUTOREPEAT_EN is defined.
module btn_debounce_ch
   import btn_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 1000000
`ifdef BTN_AUTOREPEAT_EN
   ,
   parameter int REPEAT_DELAY    = 50000000,
   parameter int REPEAT_PERIOD   = 15000000,
   parameter bit REPEAT_EN       = 1'b1
`endif
) (
   input  logic clk,
   input  logic rst,
   input  logic raw,
   output logic level,
   output logic pulse
);
   localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic             sync_meta;
   logic             sync_q;
   logic [CNT_W-1:0] cnt;
   logic             differ;
   logic             flip;
   btn_state_e       state_q;
   btn_state_e       state_d;
   logic             pulse_d;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync_meta <= 1'b0;
         sync_q    <= 1'b0;
      end else begin
         sync_meta <= raw;
         sync_q    <= sync_meta;
      end
   end

   assign level  = (state_q != ST_IDLE);
   assign differ = (sync_q != level);
   assign flip   = differ && (cnt == CNT_LAST);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt <= '0;
      end else if (!differ || flip) begin
         cnt <= '0;
      end else if (cnt != CNT_LAST) begin
         cnt <= cnt + 1'b1;
      end
   end

`ifdef BTN_AUTOREPEAT_EN
   localparam int REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
   localparam int REP_W   = (REP_MAX > 1) ? $clog2(REP_MAX) : 1;

   logic [REP_W-1:0] rep_cnt;
   logic             rep_delay_hit;
   logic             rep_period_hit;

   assign rep_delay_hit  = REPEAT_EN && (rep_cnt == REP_W'(REPEAT_DELAY - 1));
   assign rep_period_hit = REPEAT_EN && (rep_cnt == REP_W'(REPEAT_PERIOD - 1));

   // Restart the hold timer on every state change and on every emitted pulse.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rep_cnt <= '0;
      end else if (!REPEAT_EN || state_q == ST_IDLE || state_d != state_q || pulse_d) begin
         rep_cnt <= '0;
      end else begin
         rep_cnt <= rep_cnt + 1'b1;
      end
   end
`endif

   always_comb begin
      state_d = state_q;
      pulse_d = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (flip) begin
               state_d = ST_PRESSED;
               pulse_d = 1'b1;
            end
         end
         ST_PRESSED: begin
            if (flip) begin
               state_d = ST_IDLE;
            end
`ifdef BTN_AUTOREPEAT_EN
            else if (rep_delay_hit) begin
               state_d = ST_REPEATING;
               pulse_d = 1'b1;
            end
`endif
         end
`ifdef BTN_AUTOREPEAT_EN
         ST_REPEATING: begin
            if (flip) begin
               state_d = ST_IDLE;
            end else if (rep_period_hit) begin
               pulse_d = 1'b1;
            end
         end
`endif
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         pulse   <= 1'b0;
      end else begin
         state_q <= state_d;
         pulse   <= pulse_d;
      end
   end
endmodule

// File: rtl/button_conditioner.sv
// Debounces six async buttons into levels and single-cycle press pulses; resetGame masks the others.
// Macro BTN_AUTOREPEAT_EN adds auto-repeat pulses on the four direction buttons.
module button_conditioner
   import btn_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 1000000,
   parameter int REPEAT_DELAY    = 50000000,
   parameter int REPEAT_PERIOD   = 15000000
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [NUM_BTN-1:0] btn_raw,
   output logic [NUM_BTN-1:0] btn_level,
   output logic [NUM_BTN-1:0] btn_pulse
);
   logic [NUM_BTN-1:0] ch_pulse;

   if (DEBOUNCE_CYCLES < 2 || DEBOUNCE_CYCLES > 16777215 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1)
   begin : g_param_check
      $error("button_conditioner: illegal timing parameters");
   end

   for (genvar i = 0; i < NUM_BTN; i++) begin : g_ch
      btn_debounce_ch #(
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
`ifdef BTN_AUTOREPEAT_EN
         ,
         .REPEAT_DELAY    (REPEAT_DELAY),
         .REPEAT_PERIOD   (REPEAT_PERIOD),
         .REPEAT_EN       (i < NUM_DIR_BTN)
`endif
      ) u_ch (
         .clk   (clk),
         .rst   (rst),
         .raw   (btn_raw[i]),
         .level (btn_level[i]),
         .pulse (ch_pulse[i])
      );
   end

   // A game reset wins over any move or marker strobe in the same cycle.
   always_comb begin
      btn_pulse = ch_pulse;
      if (ch_pulse[BTN_RESET]) begin
         btn_pulse[BTN_RESET-1:0] = '0;
      end
   end
endmodule
